alu_seq: RTL and testbench

//   Parametrised, registered successor to the combinational MIPS ALU.
//   - Executes the existing 4-bit alu_control op set with 1-cycle registered latency.
//   - Adds iterative multiply/divide units writing HI/LO registers.
//   - Uses a valid/ready handshake on both sides, so the execute stage can stall
//     on multi-cycle operations.
//   - Sits between the ID/EX register and the EX/MEM register of the MIPS datapath.

---
 rtl/alu_seq.sv | 263 ++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Purpose  : Registered MIPS execute-stage ALU. Simple ops complete with a
//            one-cycle registered latency; MUL and DIV run on iterative
//            one-bit-per-cycle units and write the HI/LO registers.
//            Valid/ready handshakes on both sides let the execute stage stall
//            while a multi-cycle operation is in flight.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   in_valid     in   1        operation request valid
//   in_ready     out  1        request can be accepted this cycle
//   alu_control  in   4        opcode
//   in_1         in   WIDTH    operand A (rs)
//   in_2         in   WIDTH    operand B (rt or sign-extended immediate)
//   shamt        in   SHAMT_W  shift amount
//   out_valid    out  1        result valid
//   out_ready    in   1        consumer accepts the result
//   out          out  WIDTH    result
//   zero_signal  out  1        BEQ: in_1==in_2, otherwise out==0
//   div_by_zero  out  1        DIV issued with in_2==0 (qualified by out_valid)
//   hi, lo       out  WIDTH    HI/LO registers
// ============================================================================
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_control,
  input  logic [WIDTH-1:0]   in_1,
  input  logic [WIDTH-1:0]   in_2,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               zero_signal,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  // --------------------------------------------------------------------------
  // Opcode encoding
  // --------------------------------------------------------------------------
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ANDI = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_ADDI = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_SW   = 4'b1001;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_JAL  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SUB  = 4'b1110;
  localparam logic [3:0] OP_JR   = 4'b1111;

  localparam logic [SHAMT_W-1:0] C_CNT_START = SHAMT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   C_ONES      = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  state_e             state_q;
  logic [SHAMT_W-1:0] cnt_q;
  // Iteration datapath shared by MUL and DIV:
  //   MUL: work_hi_q = partial product upper half, work_lo_q = multiplier
  //        bits still to consume (shifted right, product bits enter at MSB)
  //   DIV: work_hi_q = partial remainder, work_lo_q = dividend bits shifted
  //        out at the MSB while quotient bits enter at the LSB
  logic [WIDTH-1:0]   work_hi_q;
  logic [WIDTH-1:0]   work_lo_q;
  logic [WIDTH-1:0]   opb_q;      // multiplicand or divisor
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_q;
  logic               zero_q;
  logic               dbz_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  // --------------------------------------------------------------------------
  // Combinational next-state values
  // --------------------------------------------------------------------------
  logic             in_ready_d;
  logic             accept_d;
  logic [WIDTH-1:0] simple_res_d;
  logic             simple_zero_d;
  logic [WIDTH:0]   mul_sum_d;
  logic [WIDTH-1:0] mul_hi_d;
  logic [WIDTH-1:0] mul_lo_d;
  logic [WIDTH:0]   div_trial_d;
  logic [WIDTH:0]   div_diff_d;
  logic             div_ge_d;
  logic [WIDTH-1:0] div_rem_d;
  logic [WIDTH-1:0] div_quo_d;

  // A new request may enter only when idle and the output slot is free or
  // is being drained this same cycle.
  assign in_ready_d = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept_d   = in_valid && in_ready_d;

  // Single-cycle operations
  always_comb begin
    simple_res_d = '0;
    case (alu_control)
      OP_AND, OP_ANDI:              simple_res_d = in_1 & in_2;
      OP_ADD, OP_ADDI, OP_LW, OP_SW: simple_res_d = in_1 + in_2;
      OP_SUB:                       simple_res_d = in_1 - in_2;
      OP_NOR:                       simple_res_d = ~(in_1 | in_2);
      OP_SLL:                       simple_res_d = in_1 << shamt;
      OP_SRL:                       simple_res_d = in_1 >> shamt;
      OP_SLT:                       simple_res_d = {{(WIDTH-1){1'b0}},
                                                    ($signed(in_1) < $signed(in_2))};
      OP_JAL, OP_JR:                simple_res_d = in_1;
      default:                      simple_res_d = '0;  // BEQ; MUL/DIV go elsewhere
    endcase
  end

  // BEQ reports operand equality; everything else reports a zero result.
  assign simple_zero_d = (alu_control == OP_BEQ) ? (in_1 == in_2)
                                                 : (simple_res_d == '0);

  // Shift-add multiply step: add the multiplicand when the current multiplier
  // LSB is set, then shift the whole {hi,lo} pair right by one.
  assign mul_sum_d = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi_d  = mul_sum_d[WIDTH:1];
  assign mul_lo_d  = {mul_sum_d[0], work_lo_q[WIDTH-1:1]};

  // Restoring divide step. The partial remainder is always below the divisor,
  // so the trial value is below twice the divisor and the MSB of the
  // difference is a reliable borrow flag.
  assign div_trial_d = {work_hi_q, work_lo_q[WIDTH-1]};
  assign div_diff_d  = div_trial_d - {1'b0, opb_q};
  assign div_ge_d    = ~div_diff_d[WIDTH];
  assign div_rem_d   = div_ge_d ? div_diff_d[WIDTH-1:0] : div_trial_d[WIDTH-1:0];
  assign div_quo_d   = {work_lo_q[WIDTH-2:0], div_ge_d};

  // --------------------------------------------------------------------------
  // FSM and registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      opb_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      // Drain the output slot; a result landing below overrides this.
      if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            case (alu_control)
              OP_MUL: begin
                state_q   <= S_MUL;
                cnt_q     <= C_CNT_START;
                work_hi_q <= '0;
                work_lo_q <= in_2;
                opb_q     <= in_1;
              end
              OP_DIV: begin
                if (in_2 == '0) begin
                  // Divide by zero resolves immediately without iterating.
                  out_q       <= C_ONES;
                  lo_q        <= C_ONES;
                  hi_q        <= in_1;
                  zero_q      <= 1'b0;
                  dbz_q       <= 1'b1;
                  out_valid_q <= 1'b1;
                end else begin
                  state_q   <= S_DIV;
                  cnt_q     <= C_CNT_START;
                  work_hi_q <= '0;
                  work_lo_q <= in_1;
                  opb_q     <= in_2;
                end
              end
              default: begin
                out_q       <= simple_res_d;
                zero_q      <= simple_zero_d;
                dbz_q       <= 1'b0;
                out_valid_q <= 1'b1;
              end
            endcase
          end
        end

        S_MUL: begin
          work_hi_q <= mul_hi_d;
          work_lo_q <= mul_lo_d;
          if (cnt_q == '0) begin
            state_q     <= S_IDLE;
            hi_q        <= mul_hi_d;
            lo_q        <= mul_lo_d;
            out_q       <= mul_lo_d;
            zero_q      <= (mul_lo_d == '0);
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        S_DIV: begin
          work_hi_q <= div_rem_d;
          work_lo_q <= div_quo_d;
          if (cnt_q == '0) begin
            state_q     <= S_IDLE;
            hi_q        <= div_rem_d;
            lo_q        <= div_quo_d;
            out_q       <= div_quo_d;
            zero_q      <= (div_quo_d == '0);
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_d;
  assign out_valid   = out_valid_q;
  assign out         = out_q;
  assign zero_signal = zero_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Purpose  : Directed self-checking bench for alu_seq (WIDTH = 32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_DIV  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_LW   = 4'b1000;
  localparam logic [3:0] OP_BEQ  = 4'b1010;
  localparam logic [3:0] OP_JAL  = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SRL  = 4'b1101;
  localparam logic [3:0] OP_SUB  = 4'b1110;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_control;
  logic [W-1:0] in_1;
  logic [W-1:0] in_2;
  logic [4:0]   shamt;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out;
  logic         zero_signal;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .in_1        (in_1),
    .in_2        (in_2),
    .shamt       (shamt),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out         (out),
    .zero_signal (zero_signal),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh);
    in_valid    = 1'b1;
    alu_control = op;
    in_1        = a;
    in_2        = b;
    shamt       = sh;
  endtask

  // Quick back-to-back table of simple ops
  logic [3:0]   t_op  [6];
  logic [W-1:0] t_a   [6];
  logic [W-1:0] t_b   [6];
  logic [4:0]   t_sh  [6];
  logic [W-1:0] t_res [6];
  logic         t_z   [6];

  logic seen_valid;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    alu_control = 4'b0;
    in_1        = '0;
    in_2        = '0;
    shamt       = '0;
    out_ready   = 1'b1;

    t_op[0] = OP_ADD; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'h1;         t_sh[0] = 5'd0;  t_res[0] = 32'h0;         t_z[0] = 1'b1;
    t_op[1] = OP_SLL; t_a[1] = 32'h1;         t_b[1] = 32'h0;         t_sh[1] = 5'd31; t_res[1] = 32'h8000_0000; t_z[1] = 1'b0;
    t_op[2] = OP_SRL; t_a[2] = 32'h8000_0000; t_b[2] = 32'h0;         t_sh[2] = 5'd4;  t_res[2] = 32'h0800_0000; t_z[2] = 1'b0;
    t_op[3] = OP_JAL; t_a[3] = 32'h0000_1234; t_b[3] = 32'h55;        t_sh[3] = 5'd0;  t_res[3] = 32'h0000_1234; t_z[3] = 1'b0;
    t_op[4] = OP_NOR; t_a[4] = 32'h0F0F_0F0F; t_b[4] = 32'hF0F0_F0F0; t_sh[4] = 5'd0;  t_res[4] = 32'h0;         t_z[4] = 1'b1;
    t_op[5] = OP_LW;  t_a[5] = 32'h0000_1000; t_b[5] = 32'hFFFF_FFFC; t_sh[5] = 5'd0;  t_res[5] = 32'h0000_0FFC; t_z[5] = 1'b0;

    // ---------------- Reset state ----------------
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out",       {32'd0, out},       64'd0);
    check("rst_hi",        {32'd0, hi},        64'd0);
    check("rst_lo",        {32'd0, lo},        64'd0);
    check("rst_zero",      {63'd0, zero_signal}, 64'd0);
    check("rst_dbz",       {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);

    // ---------------- 1: ADD 7+5 ----------------
    tick();
    drive(OP_ADD, 32'd7, 32'd5, 5'd0);
    tick();
    in_valid = 1'b0;
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_out",   {32'd0, out},       64'd12);
    check("add_zero",  {63'd0, zero_signal}, 64'd0);

    // ---------------- 2: SUB / BEQ / BEQ back-to-back ----------------
    drive(OP_SUB, 32'd5, 32'd5, 5'd0);
    tick();
    check("sub_valid", {63'd0, out_valid}, 64'd1);
    check("sub_out",   {32'd0, out},       64'd0);
    check("sub_zero",  {63'd0, zero_signal}, 64'd1);
    drive(OP_BEQ, 32'd9, 32'd9, 5'd0);
    tick();
    check("beq_eq_valid", {63'd0, out_valid}, 64'd1);
    check("beq_eq_out",   {32'd0, out},       64'd0);
    check("beq_eq_zero",  {63'd0, zero_signal}, 64'd1);
    drive(OP_BEQ, 32'd9, 32'd8, 5'd0);
    tick();
    in_valid = 1'b0;
    check("beq_ne_valid", {63'd0, out_valid}, 64'd1);
    check("beq_ne_out",   {32'd0, out},       64'd0);
    check("beq_ne_zero",  {63'd0, zero_signal}, 64'd0);
    check("simple_hi_untouched", {32'd0, hi}, 64'd0);
    check("simple_lo_untouched", {32'd0, lo}, 64'd0);
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);

    // ---------------- Table of simple ops, back-to-back ----------------
    for (int i = 0; i < 6; i++) begin
      drive(t_op[i], t_a[i], t_b[i], t_sh[i]);
      tick();
      check($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("tbl%0d_out", i),   {32'd0, out},       {32'd0, t_res[i]});
      check($sformatf("tbl%0d_zero", i),  {63'd0, zero_signal}, {63'd0, t_z[i]});
    end
    in_valid = 1'b0;
    tick();

    // ---------------- 3: MUL FFFFFFFF * 2 ----------------
    drive(OP_MUL, 32'hFFFF_FFFF, 32'd2, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 32; i++) begin
      check($sformatf("mul_busy_c%0d", i), {62'd0, out_valid, in_ready}, 64'd0);
      tick();
    end
    check("mul_busy_c32", {62'd0, out_valid, in_ready}, 64'd0);
    tick();
    check("mul_valid", {63'd0, out_valid}, 64'd1);
    check("mul_out",   {32'd0, out},       64'hFFFF_FFFE);
    check("mul_hi",    {32'd0, hi},        64'd1);
    check("mul_lo",    {32'd0, lo},        64'hFFFF_FFFE);
    check("mul_dbz",   {63'd0, div_by_zero}, 64'd0);
    check("mul_in_ready_after", {63'd0, in_ready}, 64'd1);

    // ---------------- 4: DIV 100/7, then DIV 5/0 ----------------
    drive(OP_DIV, 32'd100, 32'd7, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 32; i++) begin
      check($sformatf("div_busy_c%0d", i), {62'd0, out_valid, in_ready}, 64'd0);
      tick();
    end
    tick();
    check("div_valid", {63'd0, out_valid}, 64'd1);
    check("div_out",   {32'd0, out},       64'd14);
    check("div_lo",    {32'd0, lo},        64'd14);
    check("div_hi",    {32'd0, hi},        64'd2);
    check("div_dbz",   {63'd0, div_by_zero}, 64'd0);
    drive(OP_DIV, 32'd5, 32'd0, 5'd0);
    tick();
    in_valid = 1'b0;
    check("div0_valid", {63'd0, out_valid}, 64'd1);
    check("div0_out",   {32'd0, out},       64'hFFFF_FFFF);
    check("div0_lo",    {32'd0, lo},        64'hFFFF_FFFF);
    check("div0_hi",    {32'd0, hi},        64'd5);
    check("div0_dbz",   {63'd0, div_by_zero}, 64'd1);
    check("div0_zero",  {63'd0, zero_signal}, 64'd0);
    check("div0_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("div0_drain", {63'd0, out_valid}, 64'd0);

    // ---------------- 5: SLT -5<3 with output back-pressure ----------------
    out_ready = 1'b0;
    drive(OP_SLT, 32'hFFFF_FFFB, 32'd3, 5'd0);
    tick();
    drive(OP_NOR, 32'd0, 32'd0, 5'd0);  // next op waits at the input
    for (int i = 0; i < 3; i++) begin
      check($sformatf("stall%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("stall%0d_out", i),   {32'd0, out},       64'd1);
      check($sformatf("stall%0d_zero", i),  {63'd0, zero_signal}, 64'd0);
      check($sformatf("stall%0d_in_ready", i), {63'd0, in_ready}, 64'd0);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    check("unstall_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("nor_valid", {63'd0, out_valid}, 64'd1);
    check("nor_out",   {32'd0, out},       64'hFFFF_FFFF);
    check("nor_zero",  {63'd0, zero_signal}, 64'd0);
    check("nor_dbz",   {63'd0, div_by_zero}, 64'd0);
    check("nor_hi_kept", {32'd0, hi},      64'd5);
    check("nor_lo_kept", {32'd0, lo},      64'hFFFF_FFFF);
    tick();
    check("nor_drain", {63'd0, out_valid}, 64'd0);

    // ---------------- 6: reset in the middle of a MUL ----------------
    drive(OP_MUL, 32'd3, 32'd4, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    check("abort_out",   {32'd0, out},       64'd0);
    check("abort_hi",    {32'd0, hi},        64'd0);
    check("abort_lo",    {32'd0, lo},        64'd0);
    check("abort_dbz",   {63'd0, div_by_zero}, 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen_valid = seen_valid | out_valid;
    end
    check("abort_no_result", {63'd0, seen_valid}, 64'd0);
    drive(OP_AND, 32'h0000_00F0, 32'h0000_003C, 5'd0);
    tick();
    in_valid = 1'b0;
    check("and_valid", {63'd0, out_valid}, 64'd1);
    check("and_out",   {32'd0, out},       64'h30);
    check("and_zero",  {63'd0, zero_signal}, 64'd0);
    check("and_hi",    {32'd0, hi},        64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
